data_mem_arbiter: RTL and testbench

//  Shares the single-port data RAM between the processor load/store path (CPU) and a debug/loader

---
 rtl/data_mem_arbiter_if.sv | 48 ++++
 rtl/data_mem_arbiter.sv | 124 ++++++++++++
 tb/tb_data_mem_arbiter.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/data_mem_arbiter_if.sv
// rtl/data_mem_arbiter_if.sv - CPU, debug and RAM-side signal bundle for the data memory arbiter.
interface data_mem_arbiter_if #(
    parameter int DATA_WIDTH   = 32,
    parameter int MEMORY_DEPTH = 1024
);
    localparam int ADDR_W = $clog2(MEMORY_DEPTH);

    logic                  cpu_req;
    logic                  cpu_we;
    logic [31:0]           cpu_addr;
    logic [DATA_WIDTH-1:0] cpu_wdata;
    logic [DATA_WIDTH-1:0] cpu_rdata;
    logic                  cpu_ack;
    logic                  cpu_err;
    logic                  cpu_stall;

    logic                  dbg_req;
    logic                  dbg_we;
    logic [31:0]           dbg_addr;
    logic [DATA_WIDTH-1:0] dbg_wdata;
    logic [DATA_WIDTH-1:0] dbg_rdata;
    logic                  dbg_ack;
    logic                  dbg_err;

    logic [ADDR_W-1:0]     mem_addr;
    logic                  mem_we;
    logic                  mem_re;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_ack, cpu_err, cpu_stall,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output dbg_rdata, dbg_ack, dbg_err,
        output mem_addr, mem_we, mem_re, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_ack, cpu_err, cpu_stall,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  dbg_rdata, dbg_ack, dbg_err,
        input  mem_addr, mem_we, mem_re, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/data_mem_arbiter.sv
// rtl/data_mem_arbiter.sv - Single-port data RAM arbiter between CPU and debug ports.
module data_mem_arbiter #(
    parameter int          DATA_WIDTH    = 32,
    parameter int          MEMORY_DEPTH  = 1024,
    parameter logic [31:0] RAM_BASE      = 32'hEFFF_8000,
    parameter int          MAX_CPU_BURST = 4
) (
    input  logic               clk,
    input  logic               reset,
    data_mem_arbiter_if.slave  bus
);
    localparam int          ADDR_W    = $clog2(MEMORY_DEPTH);
    localparam logic [31:0] SPAN      = 32'(MEMORY_DEPTH * 4);
    localparam logic [3:0]  BURST_MAX = 4'(MAX_CPU_BURST);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SERVE = 2'd1,
        ACK   = 2'd2
    } state_t;

    state_t                stateQ, stateD;
    logic                  ownerQ;          // 1 = DBG owns the transaction
    logic                  weQ;
    logic                  errQ;
    logic [ADDR_W-1:0]     idxQ;
    logic [DATA_WIDTH-1:0] wdataQ;
    logic [DATA_WIDTH-1:0] rdataQ;
    logic [3:0]            burstCnt;

    logic                  grantCpu, grantDbg, anyGrant;
    logic                  selWe, selErr;
    logic [31:0]           selAddr, selOffset;
    logic [DATA_WIDTH-1:0] selWdata;

    // DBG wins a contested cycle only once the CPU has used up its burst allowance.
    always_comb begin
        grantDbg  = bus.dbg_req & (~bus.cpu_req | (burstCnt == BURST_MAX));
        grantCpu  = bus.cpu_req & ~grantDbg;
        anyGrant  = grantCpu | grantDbg;
        selAddr   = grantDbg ? bus.dbg_addr  : bus.cpu_addr;
        selWe     = grantDbg ? bus.dbg_we    : bus.cpu_we;
        selWdata  = grantDbg ? bus.dbg_wdata : bus.cpu_wdata;
        selOffset = selAddr - RAM_BASE;
        selErr    = (selAddr[1:0] != 2'b00) | (selOffset >= SPAN);
    end

    always_comb begin
        stateD = stateQ;
        case (stateQ)
            IDLE:    if (anyGrant) stateD = SERVE;
            SERVE:   stateD = ACK;
            ACK:     stateD = IDLE;
            default: stateD = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) stateQ <= IDLE;
        else        stateQ <= stateD;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ownerQ   <= 1'b0;
            weQ      <= 1'b0;
            errQ     <= 1'b0;
            idxQ     <= '0;
            wdataQ   <= '0;
            rdataQ   <= '0;
            burstCnt <= '0;
        end else begin
            if (stateQ == IDLE && anyGrant) begin
                ownerQ <= grantDbg;
                weQ    <= selWe;
                errQ   <= selErr;
                idxQ   <= selOffset[ADDR_W+1:2];
                wdataQ <= selWdata;
                if (grantDbg)          burstCnt <= '0;
                else if (bus.dbg_req)  burstCnt <= burstCnt + 4'd1;
                else                   burstCnt <= '0;
            end
            if (stateQ == SERVE) begin
                rdataQ <= (weQ | errQ) ? '0 : bus.mem_rdata;
            end
        end
    end

    always_comb begin
        bus.mem_addr  = '0;
        bus.mem_we    = 1'b0;
        bus.mem_re    = 1'b0;
        bus.mem_wdata = '0;
        bus.cpu_ack   = 1'b0;
        bus.cpu_err   = 1'b0;
        bus.cpu_rdata = '0;
        bus.dbg_ack   = 1'b0;
        bus.dbg_err   = 1'b0;
        bus.dbg_rdata = '0;
        case (stateQ)
            SERVE: begin
                bus.mem_addr  = idxQ;
                // Gated by reset so a write caught by reset never lands in RAM.
                bus.mem_we    = weQ & ~errQ & reset;
                bus.mem_re    = ~weQ & ~errQ;
                bus.mem_wdata = wdataQ;
            end
            ACK: begin
                if (ownerQ) begin
                    bus.dbg_ack   = 1'b1;
                    bus.dbg_err   = errQ;
                    bus.dbg_rdata = rdataQ;
                end else begin
                    bus.cpu_ack   = 1'b1;
                    bus.cpu_err   = errQ;
                    bus.cpu_rdata = rdataQ;
                end
            end
            default: ;
        endcase
    end

    assign bus.cpu_stall = bus.cpu_req & ~bus.cpu_ack;
endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb/tb_data_mem_arbiter.sv - Directed self-checking bench for data_mem_arbiter.
module tb_data_mem_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    data_mem_arbiter_if #(.DATA_WIDTH(32), .MEMORY_DEPTH(1024)) bus ();

    data_mem_arbiter #(
        .DATA_WIDTH(32), .MEMORY_DEPTH(1024),
        .RAM_BASE(32'hEFFF_8000), .MAX_CPU_BURST(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    logic [31:0] ram [1024];
    assign bus.mem_rdata = ram[bus.mem_addr];
    always @(posedge clk) if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;

    int          weCount = 0, reCount = 0;
    logic [9:0]  lastWeIdx = '0, lastReIdx = '0;
    logic [31:0] lastWdata = '0;
    always @(negedge clk) begin
        if (bus.mem_we) begin
            weCount++;
            lastWeIdx = bus.mem_addr;
            lastWdata = bus.mem_wdata;
        end
        if (bus.mem_re) begin
            reCount++;
            lastReIdx = bus.mem_addr;
        end
    end

    int total = 0;
    int bad = 0;

    task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", tag, obs, exp);
        end
    endtask

    task automatic xfer(input bit isDbg, input logic we, input logic [31:0] addr,
                        input logic [31:0] wd, output logic [31:0] rd, output logic er,
                        output int lat, output int stalls, output bit otherAck);
        bit got;
        got = 0; rd = '0; er = 1'b0; lat = 0; stalls = 0; otherAck = 0;
        @(posedge clk); #1;
        if (isDbg) begin
            bus.dbg_req = 1'b1; bus.dbg_we = we; bus.dbg_addr = addr; bus.dbg_wdata = wd;
        end else begin
            bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = wd;
        end
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            lat++;
            if (!isDbg && bus.cpu_stall) stalls++;
            if (isDbg ? bus.cpu_ack : bus.dbg_ack) otherAck = 1;
            if (isDbg ? bus.dbg_ack : bus.cpu_ack) begin
                got = 1;
                rd  = isDbg ? bus.dbg_rdata : bus.cpu_rdata;
                er  = isDbg ? bus.dbg_err   : bus.cpu_err;
            end
        end
        checkEq("ack_seen", 32'(got), 32'd1);
        @(posedge clk); #1;
        bus.cpu_req = 1'b0;
        bus.dbg_req = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat, stalls, we0, re0, acks;
        bit          other, ackSeen;
        logic [9:0]  seq;

        bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = 0; bus.cpu_wdata = 0;
        bus.dbg_req = 0; bus.dbg_we = 0; bus.dbg_addr = 0; bus.dbg_wdata = 0;

        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        checkEq("rst_cpu_ack", 32'(bus.cpu_ack), 0);
        checkEq("rst_dbg_ack", 32'(bus.dbg_ack), 0);
        checkEq("rst_stall",   32'(bus.cpu_stall), 0);
        checkEq("rst_mem",     {bus.mem_addr, bus.mem_we, bus.mem_re}, 0);

        // CPU write then read-back at word 4
        xfer(0, 1'b1, 32'hEFFF_8010, 32'hDEAD_BEEF, rd, er, lat, stalls, other);
        checkEq("wr_latency", 32'(lat), 3);
        checkEq("wr_stalls",  32'(stalls), 2);
        checkEq("wr_err",     32'(er), 0);
        checkEq("wr_rdata",   rd, 0);
        checkEq("wr_count",   32'(weCount), 1);
        checkEq("wr_idx",     32'(lastWeIdx), 4);
        checkEq("wr_data",    lastWdata, 32'hDEAD_BEEF);
        checkEq("wr_no_dbg",  32'(other), 0);

        xfer(0, 1'b0, 32'hEFFF_8010, 0, rd, er, lat, stalls, other);
        checkEq("rd_rdata",   rd, 32'hDEAD_BEEF);
        checkEq("rd_err",     32'(er), 0);
        checkEq("rd_count",   32'(reCount), 1);
        checkEq("rd_idx",     32'(lastReIdx), 4);

        // DBG at the last valid word
        xfer(1, 1'b1, 32'hEFFF_8FFC, 32'h1234_5678, rd, er, lat, stalls, other);
        checkEq("dbg_wr_err", 32'(er), 0);
        checkEq("dbg_wr_idx", 32'(lastWeIdx), 1023);
        checkEq("dbg_no_cpu", 32'(other), 0);
        xfer(1, 1'b0, 32'hEFFF_8FFC, 0, rd, er, lat, stalls, other);
        checkEq("dbg_rd",     rd, 32'h1234_5678);
        checkEq("dbg_rd_lat", 32'(lat), 3);

        // Erroneous accesses never reach RAM
        we0 = weCount; re0 = reCount;
        xfer(1, 1'b0, 32'hEFFF_8002, 0, rd, er, lat, stalls, other);
        checkEq("mis_err",    32'(er), 1);
        checkEq("mis_rdata",  rd, 0);
        xfer(1, 1'b0, 32'hEFFF_9000, 0, rd, er, lat, stalls, other);
        checkEq("oor_err",    32'(er), 1);
        checkEq("oor_rdata",  rd, 0);
        xfer(0, 1'b1, 32'h0000_0000, 32'h5555_AAAA, rd, er, lat, stalls, other);
        checkEq("zero_err",   32'(er), 1);
        checkEq("err_no_mem", 32'(weCount - we0 + reCount - re0), 0);

        // Both ports held: expect CPU x4 then DBG, twice (bit = 1 for DBG)
        @(posedge clk); #1;
        bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 32'hEFFF_8010;
        bus.dbg_req = 1; bus.dbg_we = 0; bus.dbg_addr = 32'hEFFF_8FFC;
        seq = '0; acks = 0;
        for (int i = 0; i < 100 && acks < 10; i++) begin
            @(negedge clk);
            if (bus.cpu_ack || bus.dbg_ack) begin
                seq = {seq[8:0], bus.dbg_ack};
                acks++;
            end
        end
        @(posedge clk); #1;
        bus.cpu_req = 0; bus.dbg_req = 0;
        checkEq("arb_acks",  32'(acks), 10);
        checkEq("arb_order", 32'(seq), 32'b00_0010_0001);

        // Reset lands while a CPU write is in SERVE
        we0 = weCount;
        @(posedge clk); #1;
        bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 32'hEFFF_8020; bus.cpu_wdata = 32'hCAFE_F00D;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        checkEq("rst_serve_we", 32'(bus.mem_we), 0);
        @(posedge clk); #1;
        bus.cpu_req = 0;
        @(negedge clk);
        checkEq("rst_after_out", {bus.cpu_ack, bus.cpu_err, bus.cpu_stall, bus.mem_we,
                                  bus.mem_re, bus.dbg_ack}, 0);
        checkEq("rst_after_bus", {bus.cpu_rdata[21:0], bus.mem_addr}, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        ackSeen = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus.cpu_ack || bus.dbg_ack || bus.mem_we || bus.mem_re) ackSeen = 1;
        end
        checkEq("rst_no_ack",   32'(ackSeen), 0);
        checkEq("rst_no_write", 32'(weCount - we0), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
